// File: rtl/centroid_calc_pkg.sv
// centroid_calc_pkg: shared constants and FSM state type for the centroid block
package centroid_calc_pkg;
   localparam int IMG_W_DEF = 1280;
   localparam int IMG_H_DEF = 720;
   localparam int QW_DEF    = 11;
   localparam int CNT_W     = 20;
   localparam int SUM_W     = 32;
   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;
endpackage

// File: rtl/centroid_calc_if.sv
// centroid_calc_if: pixel stream in, centroid result out
//   de/hsync/vsync/mask : video timing and object mask (master drives)
//   x_center/y_center   : centroid coordinates (slave drives)
//   found/valid         : frame had object / one-cycle update strobe (slave drives)
interface centroid_calc_if import centroid_calc_pkg::*; #(parameter int QW = QW_DEF) ();
   logic          de;
   logic          hsync;
   logic          vsync;
   logic          mask;
   logic [QW-1:0] x_center;
   logic [QW-1:0] y_center;
   logic          found;
   logic          valid;
   modport master (output de, hsync, vsync, mask, input x_center, y_center, found, valid);
   modport slave  (input de, hsync, vsync, mask, output x_center, y_center, found, valid);
endinterface

// File: rtl/centroid_calc_seq_div.sv
// centroid_calc_seq_div: restoring divider, one quotient bit per cycle, MSB first
//   clk, rst_n   : clock, synchronous active-low reset
//   i_start      : load operands and compute the first quotient bit
//   i_dividend   : SUM_W-bit dividend, quotient must fit in QW bits
//   i_divisor    : CNT_W-bit non-zero divisor
//   o_quotient   : floor(dividend/divisor), held until the next start
//   o_done       : high for the cycle in which o_quotient is final
module centroid_calc_seq_div import centroid_calc_pkg::*; #(
   parameter int QW = QW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [SUM_W-1:0] i_dividend,
   input  logic [CNT_W-1:0] i_divisor,
   output logic [QW-1:0]    o_quotient,
   output logic             o_done
);
   localparam int CW = $clog2(QW + 1);
   logic [CNT_W-1:0] r_rem, r_dvs, w_rem_in, w_dvs;
   logic [QW-1:0]    r_dq, w_dq_in;
   logic [CW-1:0]    r_cnt;
   logic             r_busy, w_ge;
   logic [CNT_W:0]   w_trial, w_diff;
   // The dividend's upper bits seed the remainder: they are already below the
   // divisor because the quotient fits in QW bits. r_dq shifts dividend bits out
   // at the top while quotient bits shift in at the bottom.
   assign w_rem_in   = i_start ? CNT_W'(i_dividend >> QW) : r_rem;
   assign w_dq_in    = i_start ? i_dividend[QW-1:0] : r_dq;
   assign w_dvs      = i_start ? i_divisor : r_dvs;
   assign w_trial    = {w_rem_in, w_dq_in[QW-1]};
   assign w_diff     = w_trial - {1'b0, w_dvs};
   assign w_ge       = w_trial >= {1'b0, w_dvs};
   assign o_quotient = r_dq;
   assign o_done     = r_busy && r_cnt == '0;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_rem  <= '0;
         r_dq   <= '0;
         r_dvs  <= '0;
      end else if (i_start || (r_busy && r_cnt != '0)) begin
         r_rem  <= CNT_W'(w_ge ? w_diff : w_trial);
         r_dq   <= {w_dq_in[QW-2:0], w_ge};
         r_dvs  <= w_dvs;
         r_busy <= 1'b1;
         r_cnt  <= i_start ? CW'(QW - 1) : r_cnt - CW'(1);
      end else begin
         r_busy <= 1'b0;
      end
   end
endmodule

// File: rtl/centroid_calc.sv
// centroid_calc: per-frame centroid of a 1-bit object mask on a de/vsync pixel stream
//   clk, rst_n : pixel clock, synchronous active-low reset
//   bus        : centroid_calc_if slave; de/hsync/vsync/mask in,
//                x_center/y_center/found/valid out (registered, held between pulses)
module centroid_calc import centroid_calc_pkg::*; #(
   parameter int IMG_W      = IMG_W_DEF,
   parameter int IMG_H      = IMG_H_DEF,
   parameter int QW         = QW_DEF,
   parameter int MIN_PIXELS = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   centroid_calc_if.slave bus
);
   logic             r_vsync_d, w_edge, w_cnt_ok, w_snap_ok, w_unused;
   logic [QW-1:0]    r_x_pos, r_y_pos, r_qx, r_x_center, r_y_center, w_quo;
   logic [CNT_W-1:0] r_cnt, r_snap_cnt, w_divisor;
   logic [SUM_W-1:0] r_sum_x, r_sum_y, r_snap_sy, w_dividend;
   logic             r_found, r_valid, w_start, w_div_done;
   state_t           r_state, w_state_nx;
   assign w_edge    = bus.vsync & ~r_vsync_d;
   assign w_cnt_ok  = r_cnt >= CNT_W'(MIN_PIXELS);
   assign w_snap_ok = r_snap_cnt >= CNT_W'(MIN_PIXELS);
   assign w_unused  = bus.hsync;
   always_ff @(posedge clk) begin
      if (!rst_n || bus.vsync) begin
         r_x_pos <= '0;
         r_y_pos <= '0;
      end else if (bus.de) begin
         r_x_pos <= (r_x_pos == QW'(IMG_W - 1)) ? '0 : r_x_pos + QW'(1);
         if (r_x_pos == QW'(IMG_W - 1))
            r_y_pos <= (r_y_pos == QW'(IMG_H - 1)) ? '0 : r_y_pos + QW'(1);
      end
   end
   // Accumulators restart on every frame edge, even when the divider is busy
   // and that frame's totals are discarded.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vsync_d <= 1'b0;
         r_cnt     <= '0;
         r_sum_x   <= '0;
         r_sum_y   <= '0;
      end else begin
         r_vsync_d <= bus.vsync;
         if (w_edge) begin
            r_cnt   <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
         end else if (bus.de && bus.mask && !bus.vsync) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_sum_x <= r_sum_x + SUM_W'(r_x_pos);
            r_sum_y <= r_sum_y + SUM_W'(r_y_pos);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_state_nx;
   end
   // X division starts straight from the live totals at the edge; Y uses the
   // snapshot because the live accumulators are cleared at that same edge.
   always_comb begin
      w_state_nx = r_state;
      w_start    = 1'b0;
      w_dividend = r_sum_x;
      w_divisor  = r_cnt;
      case (r_state)
         IDLE: if (w_edge) begin
            w_state_nx = w_cnt_ok ? DIV_X : DONE;
            w_start    = w_cnt_ok;
         end
         DIV_X: if (w_div_done) begin
            w_state_nx = DIV_Y;
            w_start    = 1'b1;
            w_dividend = r_snap_sy;
            w_divisor  = r_snap_cnt;
         end
         DIV_Y: if (w_div_done) w_state_nx = DONE;
         default: w_state_nx = IDLE;
      endcase
   end
   // In DONE the divider is idle and still holds the Y quotient.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_snap_cnt <= '0;
         r_snap_sy  <= '0;
         r_qx       <= '0;
         r_x_center <= QW'(IMG_W / 2);
         r_y_center <= QW'(IMG_H / 2);
         r_found    <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_valid <= r_state == DONE;
         if (r_state == IDLE && w_edge) begin
            r_snap_cnt <= r_cnt;
            r_snap_sy  <= r_sum_y;
         end
         if (r_state == DIV_X && w_div_done) r_qx <= w_quo;
         if (r_state == DONE) begin
            r_found <= w_snap_ok;
            if (w_snap_ok) begin
               r_x_center <= r_qx;
               r_y_center <= w_quo;
            end
         end
      end
   end
   centroid_calc_seq_div #(.QW(QW)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_start),
      .i_dividend (w_dividend),
      .i_divisor  (w_divisor),
      .o_quotient (w_quo),
      .o_done     (w_div_done)
   );
   assign bus.x_center = r_x_center;
   assign bus.y_center = r_y_center;
   assign bus.found    = r_found;
   assign bus.valid    = r_valid;
endmodule

// File: tb/tb_centroid_calc.sv
// tb_centroid_calc: directed frames on a reduced 64x48 image with hand-computed centroids
module tb_centroid_calc;
   localparam int W  = 64;
   localparam int H  = 48;
   localparam int QW = 11;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_checks = 0, n_errors = 0;
   int edge_cnt = 0, n_valid = 0, t_valid = 0, t_edge = 0, v0 = 0;
   always #5 clk = ~clk;
   centroid_calc_if #(.QW(QW)) bus ();
   centroid_calc #(.IMG_W(W), .IMG_H(H), .QW(QW), .MIN_PIXELS(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      if (bus.valid) begin
         n_valid <= n_valid + 1;
         t_valid <= edge_cnt;
      end
   end
   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic logic mask_at(input int kind, input int x, input int y, input int ax, input int ay);
      case (kind)
         1: return x == ax && y == ay;
         2: return x >= ax && x < ax + 10 && y >= ay && y < ay + 10;
         3: return 1'b1;
         4: return (x == 0 && y == 0) || (x == W - 1 && y == H - 1);
         default: return 1'b0;
      endcase
   endfunction
   task automatic frame(input int kind, input int ax, input int ay);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            @(negedge clk);
            bus.de   = 1'b1;
            bus.mask = mask_at(kind, x, y, ax, ay);
         end
         @(negedge clk);
         bus.de    = 1'b0;
         bus.mask  = kind == 3;
         bus.hsync = 1'b1;
         @(negedge clk);
         bus.hsync = 1'b0;
         @(negedge clk);
         bus.mask  = 1'b0;
      end
   endtask
   task automatic frame_end(input int rst_at);
      v0 = n_valid;
      @(negedge clk);
      bus.de    = 1'b0;
      bus.mask  = 1'b0;
      bus.vsync = 1'b1;
      t_edge    = edge_cnt + 1;
      for (int i = 1; i < 45; i++) begin
         @(negedge clk);
         if (i == 4) bus.vsync = 1'b0;
         if (rst_at != 0 && edge_cnt == t_edge + rst_at - 1) rst_n = 1'b0;
         if (rst_at != 0 && edge_cnt == t_edge + rst_at + 2) rst_n = 1'b1;
      end
   endtask
   task automatic result(input string tag, input int ex, input int ey, input int ef, input int ep, input int el);
      check({tag, "_x"}, int'(bus.x_center), ex);
      check({tag, "_y"}, int'(bus.y_center), ey);
      check({tag, "_found"}, int'(bus.found), ef);
      check({tag, "_pulses"}, n_valid - v0, ep);
      if (ep != 0) check({tag, "_latency"}, t_valid - t_edge, el);
   endtask
   initial begin
      bus.de    = 1'b0;
      bus.hsync = 1'b0;
      bus.vsync = 1'b0;
      bus.mask  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("rst_x", int'(bus.x_center), 32);
      check("rst_y", int'(bus.y_center), 24);
      check("rst_found", int'(bus.found), 0);
      check("rst_valid", n_valid, 0);
      frame(1, 10, 5);
      frame_end(0);
      result("single", 10, 5, 1, 1, 23);
      frame(2, 20, 30);
      frame_end(0);
      result("block", 24, 34, 1, 1, 23);
      frame(0, 0, 0);
      frame_end(0);
      result("empty", 24, 34, 0, 1, 1);
      frame(3, 0, 0);
      frame_end(0);
      result("full", 31, 23, 1, 1, 23);
      frame(4, 0, 0);
      frame_end(0);
      result("corner", 31, 23, 1, 1, 23);
      frame(1, 10, 5);
      frame_end(10);
      result("abort", 32, 24, 0, 0, 0);
      frame(1, 7, 3);
      frame_end(0);
      result("after_rst", 7, 3, 1, 1, 23);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
